// File: rtl/darkroom_sensor_config_scheduler_pkg.sv
// darkroom_pkg: shared definitions for the sensor configuration scheduler.
//   - TS4231 sensor state codes as reported by the ts4231 engine
//   - scheduler FSM state enum
//   - constant clog2 helper for parameter-derived widths
package darkroom_pkg;

  localparam logic [2:0] UNKNOWN = 3'd0;
  localparam logic [2:0] S_SLEEP = 3'd1;
  localparam logic [2:0] S_WATCH = 3'd2;
  localparam logic [2:0] S_S3    = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_SAMPLE,
    ST_NEXT,
    ST_WAIT_RECHECK
  } state_t;

  // Number of bits needed to index v distinct values (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/darkroom_sensor_config_scheduler_if.sv
// darkroom_sensor_config_scheduler_if: link between the scheduler and the
// shared ts4231 configuration engine.
//   master : scheduler side (drives engine reset and selected pad values)
//   slave  : engine side (drives pad drive values/enables and its state)
interface darkroom_sensor_config_scheduler_if;
  logic       eng_rst;
  logic       eng_D_i;
  logic       eng_E_i;
  logic       eng_D_o;
  logic       eng_D_oe;
  logic       eng_E_o;
  logic       eng_E_oe;
  logic [2:0] eng_state;

  modport master (
    output eng_rst, eng_D_i, eng_E_i,
    input  eng_D_o, eng_D_oe, eng_E_o, eng_E_oe, eng_state
  );

  modport slave (
    input  eng_rst, eng_D_i, eng_E_i,
    output eng_D_o, eng_D_oe, eng_E_o, eng_E_oe, eng_state
  );
endinterface

// File: rtl/darkroom_sensor_config_scheduler_pad_mux.sv
// sensor_pad_mux: steers the single engine D/E drivers onto one of
// NUM_SENSORS tristate pad pairs and returns that pair's pad values.
//   D_io/E_io : sensor pads (inout)
//   en        : routing enable (scan in progress); all pads Z when low
//   sel       : selected sensor index
//   d_o/d_oe, e_o/e_oe : engine drive value / enable
//   d_i/e_i   : selected pad values back to the engine (combinational)
module sensor_pad_mux #(
  parameter int NUM_SENSORS = 2,
  parameter int IDX_W       = 1
) (
  inout  wire  [NUM_SENSORS-1:0] D_io,
  inout  wire  [NUM_SENSORS-1:0] E_io,
  input  logic                   en,
  input  logic [IDX_W-1:0]       sel,
  input  logic                   d_o,
  input  logic                   d_oe,
  input  logic                   e_o,
  input  logic                   e_oe,
  output logic                   d_i,
  output logic                   e_i
);

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_pad
    assign D_io[g] = (en && d_oe && (sel == IDX_W'(g))) ? d_o : 1'bz;
    assign E_io[g] = (en && e_oe && (sel == IDX_W'(g))) ? e_o : 1'bz;
  end

  assign d_i = D_io[sel];
  assign e_i = E_io[sel];

endmodule

// File: rtl/darkroom_sensor_config_scheduler.sv
// darkroom_sensor_config_scheduler: configures NUM_SENSORS TS4231 sensors one
// at a time through one shared ts4231 engine, with per-attempt timeout,
// retries, a per-sensor configured flag and periodic rescans.
//   clock, reset_n : system clock, async active-low reset
//   start_scan     : 1-cycle pulse, starts a scan from idle / recheck wait
//   D_io, E_io     : sensor pads
//   eng            : engine link (master side)
//   sensor_ok      : bit i = sensor i reached WATCH on its last attempt
//   all_ok         : &sensor_ok, updated at scan completion
//   scanning       : high from ST_RESET entry to scan completion
//   cur_sensor     : index being configured
//   fail_pulse     : 1-cycle pulse when a sensor runs out of retries
module darkroom_sensor_config_scheduler
  import darkroom_pkg::*;
#(
  parameter int NUM_SENSORS    = 2,
  parameter int CLK_FREQ_HZ    = 16_000_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 10,
  parameter int MAX_RETRIES    = 2,
  parameter int RECHECK_CYCLES = CLK_FREQ_HZ,
  localparam int IDX_W = (clog2(NUM_SENSORS) < 1) ? 1 : clog2(NUM_SENSORS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start_scan,
  inout  wire  [NUM_SENSORS-1:0] D_io,
  inout  wire  [NUM_SENSORS-1:0] E_io,
  darkroom_sensor_config_scheduler_if.master eng,
  output logic [NUM_SENSORS-1:0] sensor_ok,
  output logic                   all_ok,
  output logic                   scanning,
  output logic [IDX_W-1:0]       cur_sensor,
  output logic                   fail_pulse
);

  localparam int TMO_W  = (clog2(TIMEOUT_CYCLES) < 1) ? 1 : clog2(TIMEOUT_CYCLES);
  localparam int RCHK_W = (clog2(RECHECK_CYCLES) < 1) ? 1 : clog2(RECHECK_CYCLES);
  localparam int RTRY_W = (clog2(MAX_RETRIES + 1) < 1) ? 1 : clog2(MAX_RETRIES + 1);

  state_t            state;
  logic              booted;   // first scan after reset needs no start_scan
  logic              eng_rst_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [RCHK_W-1:0] rchk_cnt;
  logic [RTRY_W-1:0] retry_cnt;

  assign eng.eng_rst = eng_rst_q;

  sensor_pad_mux #(
    .NUM_SENSORS (NUM_SENSORS),
    .IDX_W       (IDX_W)
  ) u_pad_mux (
    .D_io (D_io),
    .E_io (E_io),
    .en   (scanning),
    .sel  (cur_sensor),
    .d_o  (eng.eng_D_o),
    .d_oe (eng.eng_D_oe),
    .e_o  (eng.eng_E_o),
    .e_oe (eng.eng_E_oe),
    .d_i  (eng.eng_D_i),
    .e_i  (eng.eng_E_i)
  );

  // Engine is held in reset whenever no attempt is running; it is released
  // only for ST_RUN and the following sample/next cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      booted     <= 1'b0;
      eng_rst_q  <= 1'b1;
      tmo_cnt    <= '0;
      rchk_cnt   <= '0;
      retry_cnt  <= '0;
      sensor_ok  <= '0;
      all_ok     <= 1'b0;
      scanning   <= 1'b0;
      cur_sensor <= '0;
      fail_pulse <= 1'b0;
    end else begin
      fail_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!booted || start_scan) begin
            booted    <= 1'b1;
            scanning  <= 1'b1;
            eng_rst_q <= 1'b1;
            state     <= ST_RESET;
          end
        end
        ST_RESET: begin
          tmo_cnt   <= '0;
          eng_rst_q <= 1'b0;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) state <= ST_SAMPLE;
          else tmo_cnt <= tmo_cnt + 1'b1;
        end
        ST_SAMPLE: begin
          if (eng.eng_state == S_WATCH) begin
            sensor_ok[cur_sensor] <= 1'b1;
            retry_cnt             <= '0;
            state                 <= ST_NEXT;
          end else if (retry_cnt < RTRY_W'(MAX_RETRIES)) begin
            retry_cnt <= retry_cnt + 1'b1;
            eng_rst_q <= 1'b1;
            state     <= ST_RESET;
          end else begin
            sensor_ok[cur_sensor] <= 1'b0;
            fail_pulse            <= 1'b1;
            retry_cnt             <= '0;
            state                 <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          eng_rst_q <= 1'b1;
          if (cur_sensor != IDX_W'(NUM_SENSORS - 1)) begin
            cur_sensor <= cur_sensor + 1'b1;
            state      <= ST_RESET;
          end else begin
            cur_sensor <= '0;
            scanning   <= 1'b0;
            all_ok     <= &sensor_ok;
            rchk_cnt   <= '0;
            state      <= (RECHECK_CYCLES > 0) ? ST_WAIT_RECHECK : ST_IDLE;
          end
        end
        ST_WAIT_RECHECK: begin
          if (start_scan || (rchk_cnt == RCHK_W'(RECHECK_CYCLES - 1))) begin
            rchk_cnt <= '0;
            scanning <= 1'b1;
            state    <= ST_RESET;
          end else begin
            rchk_cnt <= rchk_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
